// File: rtl/npc_ifu_prefetch_if.sv
// Fetch-unit bundle: redirect input, instruction-memory request/response channels and IDU output.
// The fetch unit connects through `master`; memory, execute and IDU connect through `slave`.
interface npc_ifu_prefetch_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4
);
    logic                       jump_en;
    logic [XLEN-1:0]            jump_pc;
    logic                       imem_req_valid;
    logic                       imem_req_ready;
    logic [XLEN-1:0]            imem_req_addr;
    logic                       imem_rsp_valid;
    logic [XLEN-1:0]            imem_rsp_data;
    logic                       out_valid;
    logic                       out_ready;
    logic [XLEN-1:0]            out_inst;
    logic [XLEN-1:0]            out_pc;
    logic [$clog2(DEPTH):0]     occupancy;

    modport master (
        input  jump_en, jump_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready,
        output imem_req_valid, imem_req_addr, out_valid, out_inst, out_pc, occupancy
    );

    modport slave (
        output jump_en, jump_pc, imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready,
        input  imem_req_valid, imem_req_addr, out_valid, out_inst, out_pc, occupancy
    );
endinterface

// File: rtl/npc_ifu_prefetch.sv
// Prefetching IFU: DEPTH-entry in-order queue with up to DEPTH outstanding imem requests.
// Define IFU_PERF_EN to add the perf_flush_cnt / perf_stall_cnt / perf_drop_cnt counters.
module npc_ifu_prefetch #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h8000_0000)
) (
    input  logic               clk,
    input  logic               rst,
    npc_ifu_prefetch_if.master bus
`ifdef IFU_PERF_EN
    ,
    output logic [31:0]        perf_flush_cnt,
    output logic [31:0]        perf_stall_cnt,
    output logic [31:0]        perf_drop_cnt
`endif
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]   DepthC = CW'(DEPTH);
    localparam logic [XLEN-1:0] Four   = XLEN'(4);

    logic [XLEN-1:0] fpc_q, fpc_d;
    logic [XLEN-1:0] rpc_q, rpc_d;
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   occ_q, occ_d;
    logic [CW-1:0]   outst_q, outst_d;
    logic [CW-1:0]   drop_q, drop_d;

    logic [XLEN-1:0] inst_mem_q [DEPTH];
    logic [XLEN-1:0] pc_mem_q   [DEPTH];

    logic            req_valid;
    logic            req_fire;
    logic            push;
    logic            pop;
    logic            out_valid;
    logic [CW:0]     credit;

    // Credit counts queued entries plus in-flight requests so a response always has a slot.
    assign credit    = {1'b0, occ_q} + {1'b0, outst_q};
    assign req_valid = !rst && !bus.jump_en && (credit < {1'b0, DepthC});
    assign req_fire  = req_valid && bus.imem_req_ready;
    assign out_valid = (occ_q != '0);
    assign pop       = out_valid && bus.out_ready;
    assign push      = bus.imem_rsp_valid && !bus.jump_en && (drop_q == '0);

    always_comb begin
        fpc_d   = fpc_q;
        rpc_d   = rpc_q;
        head_d  = head_q;
        tail_d  = tail_q;
        occ_d   = occ_q;
        drop_d  = drop_q;
        outst_d = outst_q + CW'(req_fire) - CW'(bus.imem_rsp_valid);
        if (bus.jump_en) begin
            // Every request still in flight after this cycle belongs to the old stream.
            fpc_d  = {bus.jump_pc[XLEN-1:2], 2'b00};
            rpc_d  = {bus.jump_pc[XLEN-1:2], 2'b00};
            head_d = '0;
            tail_d = '0;
            occ_d  = '0;
            drop_d = outst_d;
        end else begin
            if (req_fire) begin
                fpc_d = fpc_q + Four;
            end
            if (bus.imem_rsp_valid && (drop_q != '0)) begin
                drop_d = drop_q - CW'(1);
            end
            if (push) begin
                tail_d = tail_q + PW'(1);
                rpc_d  = rpc_q + Four;
            end
            if (pop) begin
                head_d = head_q + PW'(1);
            end
            occ_d = occ_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fpc_q   <= RESET_PC;
            rpc_q   <= RESET_PC;
            head_q  <= '0;
            tail_q  <= '0;
            occ_q   <= '0;
            outst_q <= '0;
            drop_q  <= '0;
        end else begin
            fpc_q   <= fpc_d;
            rpc_q   <= rpc_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            occ_q   <= occ_d;
            outst_q <= outst_d;
            drop_q  <= drop_d;
        end
    end

    // Storage needs no reset: entries are only visible while counted by occ_q.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem_q[tail_q] <= bus.imem_rsp_data;
            pc_mem_q[tail_q]   <= rpc_q;
        end
    end

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = fpc_q;
    assign bus.out_valid      = out_valid;
    assign bus.out_inst       = out_valid ? inst_mem_q[head_q] : '0;
    assign bus.out_pc         = out_valid ? pc_mem_q[head_q] : rpc_q;
    assign bus.occupancy      = occ_q;

    no_overflow_a : assert property (@(posedge clk) disable iff (rst) !(push && occ_q == DepthC));

`ifdef IFU_PERF_EN
    logic [31:0] perf_flush_q, perf_flush_d;
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_drop_q, perf_drop_d;

    always_comb begin
        perf_flush_d = perf_flush_q + 32'(bus.jump_en);
        perf_stall_d = perf_stall_q + 32'(bus.out_ready && !out_valid);
        perf_drop_d  = perf_drop_q + 32'(bus.imem_rsp_valid && (bus.jump_en || drop_q != '0));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_flush_q <= '0;
            perf_stall_q <= '0;
            perf_drop_q  <= '0;
        end else begin
            perf_flush_q <= perf_flush_d;
            perf_stall_q <= perf_stall_d;
            perf_drop_q  <= perf_drop_d;
        end
    end

    assign perf_flush_cnt = perf_flush_q;
    assign perf_stall_cnt = perf_stall_q;
    assign perf_drop_cnt  = perf_drop_q;
`endif
endmodule

// File: doc/npc_ifu_prefetch.md
Name: npc_ifu_prefetch

Overview:
- Parametrised successor to the single-request IFU: an instruction fetch unit with an in-order prefetch queue of DEPTH entries and up to DEPTH outstanding memory requests.
- Sits between the instruction memory and IDU. Uses valid/ready on both sides instead of a finish pulse.
- Redirects on jump_en from the execute stage: flushes queued instructions and discards in-flight responses.

Parameters:
- XLEN, 32, width of PC, address and instruction data.
- DEPTH, 4, queue entries and maximum outstanding requests; power of two, 2..16.
- RESET_PC, 32'h8000_0000, fetch PC after reset.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- jump_en  in  1  redirect pulse from execute, one cycle.
- jump_pc  in  XLEN  redirect target; bits [1:0] ignored, treated as 0.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  XLEN  fetch address.
- imem_rsp_valid  in  1  response valid; responses return in request order; no back-pressure.
- imem_rsp_data  in  XLEN  fetched instruction.
- out_valid  out  1  instruction available to IDU.
- out_ready  in  1  IDU accepts the instruction.
- out_inst  out  XLEN  head instruction.
- out_pc  out  XLEN  PC of the head instruction.
- occupancy  out  $clog2(DEPTH)+1  number of valid queue entries.

Behaviour:
Reset (async, rst=1):
- fpc=RESET_PC, rpc=RESET_PC.
- Queue empty, outstanding=0, drop=0.
- Outputs while rst=1: out_valid=0, occupancy=0, imem_req_valid=0, imem_req_addr=RESET_PC, out_inst=0, out_pc=RESET_PC.
- Reset mid-operation discards all queue contents and pending drops immediately.

State:
- fpc is the next fetch address.
- rpc is the PC attributed to the next kept response.
- outstanding counts issued requests not yet responded.
- drop counts responses still to be discarded.

Issue:
- imem_req_valid = !rst && !jump_en && (occupancy + outstanding < DEPTH).
- imem_req_addr = fpc.
- Request handshake (valid && ready): fpc += 4, outstanding++.

Response:
- If imem_rsp_valid: outstanding-- (simultaneous issue and response leave outstanding unchanged).
- If drop>0: drop--, data discarded.
- Else: push {rpc, data} into the queue and rpc += 4.
- The credit rule guarantees the queue never overflows. A push to a full queue is an assertion failure.

Output:
- out_valid = occupancy != 0; out_inst and out_pc come from the head entry.
- Pop on out_valid && out_ready.
- Push and pop in the same cycle keep occupancy unchanged; this is legal when full or empty only where the handshake rules allow.
- Zero-latency bypass from response to output is not provided. Minimum latency from request accept to out_valid is 1 cycle after rsp_valid.

Flush (jump_en=1, highest priority):
- Next cycle: queue empty, fpc = rpc = {jump_pc[XLEN-1:2], 2'b00}.
- drop = outstanding after this cycle's response decrement.
- A response arriving in the flush cycle is discarded regardless of drop.
- No request is issued in the flush cycle.
- A pop in the flush cycle is still honoured by the IDU handshake but the queue is cleared anyway.
- Back-to-back jump_en: the last one wins, and drop accumulates correctly.

Wrap-around:
- Queue pointers wrap modulo DEPTH.
- fpc and rpc wrap modulo 2^XLEN.

Optional Feature:
- IFU_PERF_EN defined: adds outputs perf_flush_cnt (32), perf_stall_cnt (32) and perf_drop_cnt (32). All reset to 0 and wrap on overflow.
  - perf_flush_cnt counts jump_en cycles.
  - perf_stall_cnt counts cycles with out_ready=1 && out_valid=0.
  - perf_drop_cnt counts discarded responses.
- IFU_PERF_EN undefined: these ports and counters do not exist. Functional behaviour is identical.

Test Plan:
- Reset release, memory always ready, 1-cycle response latency, out_ready=1 → out_pc sequence 80000000, 80000004, 80000008… with one instruction per cycle in steady state and occupancy never above DEPTH.
- out_ready=0 with memory always ready, DEPTH=4 → exactly 4 requests issued, then occupancy=4, imem_req_valid=0. Raising out_ready resumes in order with no loss.
- jump_en with jump_pc=80000103 while 3 requests are outstanding → next 3 responses dropped. First output is out_pc=80000100 with the instruction for 80000100; queue cleared.
- jump_en in the same cycle as imem_rsp_valid and imem_req_ready=1 → no request issued, that response discarded, drop equals the remaining outstanding count.
- Two consecutive jump_en pulses (to 80000200, then 80000300) with 2 outstanding → all stale responses dropped, first out_pc=80000300.
- rst asserted mid-stream with occupancy=3 → out_valid=0 immediately; after release, fetch restarts at 80000000 and late responses from before reset are not presented (bench memory is also reset).
